// File: rtl/glb_port_arbiter_if.sv
// Bundle of requester-side and GLB-side signals for glb_port_arbiter.
// slave = arbiter view, master = requester/GLB environment view.
interface glb_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ctrl_req,    dma_req;
  logic              ctrl_last,   dma_last;
  logic [3:0]        ctrl_we,     ctrl_re,     dma_we,     dma_re;
  logic [ADDR_W-1:0] ctrl_w_addr, ctrl_r_addr, dma_w_addr, dma_r_addr;
  logic [DATA_W-1:0] ctrl_w_data, dma_w_data;

  logic              ctrl_gnt,    dma_gnt;
  logic [3:0]        glb_we,      glb_re;
  logic [ADDR_W-1:0] glb_w_addr,  glb_r_addr;
  logic [DATA_W-1:0] glb_w_data;
  logic              ctrl_rvalid, dma_rvalid;
  logic              busy;

  modport slave (
    input  ctrl_req, dma_req, ctrl_last, dma_last,
           ctrl_we, ctrl_re, dma_we, dma_re,
           ctrl_w_addr, ctrl_r_addr, dma_w_addr, dma_r_addr,
           ctrl_w_data, dma_w_data,
    output ctrl_gnt, dma_gnt, glb_we, glb_re, glb_w_addr, glb_r_addr,
           glb_w_data, ctrl_rvalid, dma_rvalid, busy
  );

  modport master (
    output ctrl_req, dma_req, ctrl_last, dma_last,
           ctrl_we, ctrl_re, dma_we, dma_re,
           ctrl_w_addr, ctrl_r_addr, dma_w_addr, dma_r_addr,
           ctrl_w_data, dma_w_data,
    input  ctrl_gnt, dma_gnt, glb_we, glb_re, glb_w_addr, glb_r_addr,
           glb_w_data, ctrl_rvalid, dma_rvalid, busy
  );
endinterface

// File: rtl/glb_port_arbiter.sv
// Round-robin CTRL/DMA arbiter for the single GLB port with burst handover.
// Optional burst cap on grant length: define GLB_ARB_BURST_LIMIT_EN.
module glb_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  glb_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CTRL = 2'd1, DMA = 2'd2} state_e;

  if ($bits(bus.glb_w_addr) != ADDR_W || $bits(bus.glb_w_data) != DATA_W)
    begin : g_bad_width
      $error("interface widths do not match ADDR_W/DATA_W");
    end
  if (BURST_MAX < 2 || BURST_MAX > 31) begin : g_bad_burst
    $error("BURST_MAX must fit the 5-bit beat counter");
  end

  state_e state_q, state_d;
  logic   last_owner_q, last_owner_d;   // 1 = DMA owned last
  logic   ctrl_rv_q, dma_rv_q;
  logic   ctrl_beat, dma_beat, own_beat, oth_req, limit_hit;

  assign ctrl_beat = (state_q == CTRL) && bus.ctrl_req;
  assign dma_beat  = (state_q == DMA)  && bus.dma_req;
  assign own_beat  = ctrl_beat || dma_beat;
  assign oth_req   = (state_q == CTRL) ? bus.dma_req : bus.ctrl_req;

`ifdef GLB_ARB_BURST_LIMIT_EN
  logic [4:0] cnt_q, cnt_d;

  // Cap only forces a handover when someone is actually waiting.
  assign limit_hit = own_beat && ((cnt_q + 5'd1) == 5'(BURST_MAX)) && oth_req;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (own_beat)      cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Dropping req without last counts as an abandoned burst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ctrl_req && bus.dma_req) state_d = last_owner_q ? CTRL : DMA;
        else if (bus.ctrl_req)           state_d = CTRL;
        else if (bus.dma_req)            state_d = DMA;
      end
      CTRL: if (!bus.ctrl_req || bus.ctrl_last || limit_hit)
              state_d = bus.dma_req ? DMA : IDLE;
      DMA:  if (!bus.dma_req || bus.dma_last || limit_hit)
              state_d = bus.ctrl_req ? CTRL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_d == CTRL)     last_owner_d = 1'b0;
    else if (state_d == DMA) last_owner_d = 1'b1;
  end

  // Read data returns one cycle after the beat, regardless of the new owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= 1'b1;
      ctrl_rv_q    <= 1'b0;
      dma_rv_q     <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      ctrl_rv_q    <= ctrl_beat && (|bus.ctrl_re);
      dma_rv_q     <= dma_beat  && (|bus.dma_re);
    end
  end

  always_comb begin
    bus.ctrl_gnt    = (state_q == CTRL);
    bus.dma_gnt     = (state_q == DMA);
    bus.busy        = (state_q != IDLE);
    bus.ctrl_rvalid = ctrl_rv_q;
    bus.dma_rvalid  = dma_rv_q;
    bus.glb_we      = '0;
    bus.glb_re      = '0;
    bus.glb_w_addr  = '0;
    bus.glb_r_addr  = '0;
    bus.glb_w_data  = '0;
    if (ctrl_beat) begin
      bus.glb_we     = bus.ctrl_we;
      bus.glb_re     = bus.ctrl_re;
      bus.glb_w_addr = bus.ctrl_w_addr;
      bus.glb_r_addr = bus.ctrl_r_addr;
      bus.glb_w_data = bus.ctrl_w_data;
    end else if (dma_beat) begin
      bus.glb_we     = bus.dma_we;
      bus.glb_re     = bus.dma_re;
      bus.glb_w_addr = bus.dma_w_addr;
      bus.glb_r_addr = bus.dma_r_addr;
      bus.glb_w_data = bus.dma_w_data;
    end
  end

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Directed scoreboard bench for glb_port_arbiter: driver queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_glb_port_arbiter;

  typedef struct packed {
    logic        cg, dg, crv, drv, busy;
    logic [3:0]  we, re;
    logic [31:0] wa, ra, wd;
  } exp_t;

  localparam logic [31:0] C_WA = 32'h0000_0100, C_RA = 32'h0000_0104;
  localparam logic [31:0] D_WA = 32'h0000_0200, D_RA = 32'h0000_0040;
  localparam logic [31:0] C_WD = 32'hCCCC_0001, D_WD = 32'hDDDD_0002;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  glb_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  glb_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   id_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  function automatic exp_t idle(input logic crv, input logic drv);
    exp_t e = '0;
    e.crv = crv; e.drv = drv;
    return e;
  endfunction

  function automatic exp_t cbeat(input logic [3:0] we, input logic [3:0] re,
                                 input logic crv, input logic drv);
    exp_t e = '0;
    e.cg = 1'b1; e.busy = 1'b1; e.crv = crv; e.drv = drv;
    e.we = we; e.re = re; e.wa = C_WA; e.ra = C_RA; e.wd = C_WD;
    return e;
  endfunction

  function automatic exp_t dbeat(input logic [3:0] we, input logic [3:0] re,
                                 input logic crv, input logic drv);
    exp_t e = '0;
    e.dg = 1'b1; e.busy = 1'b1; e.crv = crv; e.drv = drv;
    e.we = we; e.re = re; e.wa = D_WA; e.ra = D_RA; e.wd = D_WD;
    return e;
  endfunction

  task automatic step(input logic r,
                      input logic cr, input logic cl, input logic [3:0] cwe, input logic [3:0] cre,
                      input logic dr, input logic dl, input logic [3:0] dwe, input logic [3:0] dre,
                      input exp_t e);
    @(posedge clk);
    #1;
    rst           = r;
    bus.ctrl_req  = cr;  bus.ctrl_last = cl;  bus.ctrl_we = cwe;  bus.ctrl_re = cre;
    bus.dma_req   = dr;  bus.dma_last  = dl;  bus.dma_we  = dwe;  bus.dma_re  = dre;
    exp_q.push_back(e);
    id_q.push_back(step_no);
    step_no++;
  endtask

  // Monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e, a;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a.cg = bus.ctrl_gnt;    a.dg = bus.dma_gnt;
      a.crv = bus.ctrl_rvalid; a.drv = bus.dma_rvalid; a.busy = bus.busy;
      a.we = bus.glb_we;  a.re = bus.glb_re;
      a.wa = bus.glb_w_addr; a.ra = bus.glb_r_addr; a.wd = bus.glb_w_data;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL step%0d outputs: got cg=%b dg=%b crv=%b drv=%b busy=%b we=%h re=%h wa=%h ra=%h wd=%h, want cg=%b dg=%b crv=%b drv=%b busy=%b we=%h re=%h wa=%h ra=%h wd=%h",
                 id, a.cg, a.dg, a.crv, a.drv, a.busy, a.we, a.re, a.wa, a.ra, a.wd,
                 e.cg, e.dg, e.crv, e.drv, e.busy, e.we, e.re, e.wa, e.ra, e.wd);
      end
    end
  end

  initial begin
    bus.ctrl_req = 0; bus.ctrl_last = 0; bus.ctrl_we = 0; bus.ctrl_re = 0;
    bus.dma_req  = 0; bus.dma_last  = 0; bus.dma_we  = 0; bus.dma_re  = 0;
    bus.ctrl_w_addr = C_WA; bus.ctrl_r_addr = C_RA; bus.ctrl_w_data = C_WD;
    bus.dma_w_addr  = D_WA; bus.dma_r_addr  = D_RA; bus.dma_w_data  = D_WD;

    // reset state
    step(0, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(0,0));

    // ctrl alone, 3 beats, last on beat 3
    step(1, 1,0,4'hF,4'h0, 0,0,4'h0,4'h0, idle(0,0));
    step(1, 1,0,4'hF,4'h0, 0,0,4'h0,4'h0, cbeat(4'hF,4'h0,0,0));
    step(1, 1,0,4'hF,4'h0, 0,0,4'h0,4'h0, cbeat(4'hF,4'h0,0,0));
    step(1, 1,1,4'hF,4'h0, 0,0,4'h0,4'h0, cbeat(4'hF,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(0,0));

    // fresh reset, tie -> CTRL first, gapless handover to DMA
    step(0, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(0,0));
    step(1, 1,0,4'hF,4'h0, 1,0,4'h3,4'h0, idle(0,0));
    step(1, 1,0,4'hF,4'h0, 1,0,4'h3,4'h0, cbeat(4'hF,4'h0,0,0));
    step(1, 1,1,4'hF,4'h0, 1,0,4'h3,4'h0, cbeat(4'hF,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 1,0,4'h3,4'h0, dbeat(4'h3,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 1,1,4'h3,4'h0, dbeat(4'h3,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(0,0));

    // DMA read at 0x40, handover to CTRL; rvalid lands under ctrl's grant
    step(1, 0,0,4'h0,4'h0, 1,0,4'h0,4'hF, idle(0,0));
    step(1, 1,0,4'h0,4'h0, 1,1,4'h0,4'hF, dbeat(4'h0,4'hF,0,0));
    step(1, 1,1,4'h0,4'h1, 0,0,4'h0,4'h0, cbeat(4'h0,4'h1,0,1));
    step(1, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(1,0));

    // ctrl 10-beat burst with dma_req held
    step(1, 1,0,4'h1,4'h0, 0,0,4'h0,4'h0, idle(0,0));
`ifdef GLB_ARB_BURST_LIMIT_EN
    for (int i = 0; i < 4; i++)
      step(1, 1,0,4'h1,4'h0, 1,0,4'h2,4'h0, cbeat(4'h1,4'h0,0,0));
    step(1, 1,0,4'h1,4'h0, 1,0,4'h2,4'h0, dbeat(4'h2,4'h0,0,0));
    step(1, 1,0,4'h1,4'h0, 1,1,4'h2,4'h0, dbeat(4'h2,4'h0,0,0));
    for (int i = 0; i < 5; i++)
      step(1, 1,0,4'h1,4'h0, 0,0,4'h0,4'h0, cbeat(4'h1,4'h0,0,0));
    step(1, 1,1,4'h1,4'h0, 0,0,4'h0,4'h0, cbeat(4'h1,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(0,0));
`else
    for (int i = 0; i < 9; i++)
      step(1, 1,0,4'h1,4'h0, 1,0,4'h2,4'h0, cbeat(4'h1,4'h0,0,0));
    step(1, 1,1,4'h1,4'h0, 1,0,4'h2,4'h0, cbeat(4'h1,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 1,0,4'h2,4'h0, dbeat(4'h2,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 1,1,4'h2,4'h0, dbeat(4'h2,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(0,0));
`endif

    // reset during beat 2 of a DMA write burst, then CTRL wins the tie
    step(1, 0,0,4'h0,4'h0, 1,0,4'hF,4'h0, idle(0,0));
    step(1, 0,0,4'h0,4'h0, 1,0,4'hF,4'h0, dbeat(4'hF,4'h0,0,0));
    step(0, 0,0,4'h0,4'h0, 1,0,4'hF,4'h0, idle(0,0));
    step(0, 1,0,4'hF,4'h0, 1,0,4'hF,4'h0, idle(0,0));
    step(1, 1,0,4'hF,4'h0, 1,0,4'hF,4'h0, idle(0,0));
    step(1, 1,1,4'hF,4'h0, 1,0,4'hF,4'h0, cbeat(4'hF,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 1,1,4'hF,4'h0, dbeat(4'hF,4'h0,0,0));
    step(1, 0,0,4'h0,4'h0, 0,0,4'h0,4'h0, idle(0,0));

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glb_port_arbiter.md
GLB_PORT_ARBITER -- requirements
Module: glb_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the GLB byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the GLB data width.
REQ-003 The block SHALL have parameter BURST_MAX, default 16, the maximum number of beats per grant when the burst limit is compiled in.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have ports ctrl_req / dma_req, input, 1 bit each, meaning the requester wants the GLB port.
REQ-007 The block SHALL have ports ctrl_last / dma_last, input, 1 bit each, marking the final beat of a burst.
REQ-008 The block SHALL have ports ctrl_we, ctrl_re, dma_we, dma_re, input, 4 bits each, the per-byte write and read enables.
REQ-009 The block SHALL have ports ctrl_w_addr, ctrl_r_addr, dma_w_addr, dma_r_addr, input, ADDR_W each, the GLB byte addresses.
REQ-010 The block SHALL have ports ctrl_w_data / dma_w_data, input, DATA_W each, the write data.
REQ-011 The block SHALL have ports ctrl_gnt / dma_gnt, output, 1 bit each, meaning the requester owns the port this cycle.
REQ-012 The block SHALL have ports glb_we and glb_re, output, 4 bits each, and glb_w_addr and glb_r_addr, output, ADDR_W each, driving the GLB.
REQ-013 The block SHALL have port glb_w_data, output, DATA_W, the GLB write data.
REQ-014 The block SHALL have ports ctrl_rvalid / dma_rvalid, output, 1 bit each, meaning GLB dout belongs to that requester this cycle.
REQ-015 The block SHALL have port busy, output, 1 bit, high while the state is not IDLE.

Function
REQ-016 The state machine SHALL have states IDLE, CTRL and DMA; ctrl_gnt is high exactly in CTRL, and dma_gnt is high exactly in DMA; grants are registered.
REQ-017 A beat SHALL occur when the owner's req and gnt are both high; only on a beat are the owner's we/re/addr/data forwarded, otherwise glb_we = glb_re = 0 and addresses/data hold 0.
REQ-018 IDLE SHALL move to CTRL or DMA one cycle after a request; the grant latency is 1 cycle.
REQ-019 When both requests are high in IDLE, the winner SHALL be the opposite of a 1-bit last_owner register (round-robin); last_owner updates on every grant.
REQ-020 On a beat with last=1, the next state SHALL be the other requester if its req is high, else IDLE; no idle bubble occurs when a handover is pending.
REQ-021 If the owner deasserts req without last while granted, the block SHALL treat the burst as abandoned and follow REQ-020 on the next cycle.
REQ-022 ctrl_rvalid/dma_rvalid SHALL be asserted one cycle after a beat with nonzero re from that requester, matching the 1-cycle GLB read latency, even if ownership has changed since.
REQ-023 A 5-bit beat counter SHALL clear on every grant change and increment on every beat.

Reset
REQ-024 When rst is low, state SHALL be IDLE, last_owner SHALL be DMA (so CTRL wins the first tie), the beat counter SHALL be 0, and all outputs SHALL be 0.
REQ-025 Reset asserted mid-burst SHALL drop the grant immediately, with no GLB write issued in that cycle.

Configuration
REQ-026 With GLB_ARB_BURST_LIMIT_EN defined, a beat that brings the counter to BURST_MAX SHALL force the REQ-020 handover as if last=1, provided the other req is high.
REQ-027 Without GLB_ARB_BURST_LIMIT_EN, a grant SHALL be held until last or abandonment, and the counter SHALL be removed.

Verification
REQ-028 A bench SHALL cover: ctrl_req=1 alone with 3 beats, last on beat 3 -> ctrl_gnt high cycles 1-3, glb_we mirrors ctrl_we, busy falls at cycle 4.
REQ-029 A bench SHALL cover: both req high after reset -> CTRL granted first; on ctrl's last beat, dma_gnt is high the next cycle with no gap.
REQ-030 A bench SHALL cover: a DMA read beat at addr 0x40 and then a handover to CTRL -> dma_rvalid is high exactly one cycle later, while ctrl_gnt is already high.
REQ-031 A bench SHALL cover: with the macro defined and BURST_MAX=4, ctrl bursting 10 beats with dma_req held -> dma_gnt after beat 4 of ctrl, then ctrl regains the grant after dma's last beat.
REQ-032 A bench SHALL cover: rst low during beat 2 of a DMA write burst -> all grants and glb_we are 0 immediately, and after release CTRL wins the tie.
